// File: rtl/key_sched_ctrl_if.sv
// Round-key stream and g-function side channel for the AES-128 key expansion sequencer.
// The slave modport is the sequencer's view; the master modport is the surrounding logic.
interface key_sched_ctrl_if;
   logic         start;
   logic [127:0] key_in;
   logic         busy;
   logic         rk_valid;
   logic         rk_ready;
   logic [3:0]   rk_idx;
   logic [127:0] rk_data;
   logic         done;
   logic [3:0]   g_round_sel;
   logic         g_flag;
   logic [31:0]  g_w_in;
   logic [31:0]  g_out_in;

   modport slave (
      input  start, key_in, rk_ready, g_out_in,
      output busy, rk_valid, rk_idx, rk_data, done, g_round_sel, g_flag, g_w_in
   );

   modport master (
      output start, key_in, rk_ready, g_out_in,
      input  busy, rk_valid, rk_idx, rk_data, done, g_round_sel, g_flag, g_w_in
   );
endinterface

// File: rtl/key_sched_ctrl.sv
// AES-128 key expansion sequencer: latches the cipher key on start and streams
// round keys 0..10 over valid/ready, using an external g-function (SubWord/RotWord/Rcon).
module key_sched_ctrl #(
   parameter int NUM_ROUNDS = 10
) (
   input logic            clk,
   input logic            rst_n,
   key_sched_ctrl_if.slave bus
);

   if (NUM_ROUNDS != 10) begin : g_num_rounds_check
      $error("key_sched_ctrl supports only AES-128 (NUM_ROUNDS = 10)");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t       state;
   state_t       next_state;
   logic [127:0] rk_data_q;
   logic [3:0]   rk_idx_q;
   logic         accept;
   logic         last_key;
   logic [31:0]  w4, w5, w6, w7;

   logic         busy_o;
   logic         rk_valid_o;
   logic         done_o;
   logic [3:0]   g_round_sel_o;
   logic         g_flag_o;

   assign accept   = (state == EMIT) && bus.rk_ready;
   assign last_key = (rk_idx_q == 4'(NUM_ROUNDS));

   // Next round key from the current one; the g-function result closes the loop on word 3.
   assign w4 = rk_data_q[127:96] ^ bus.g_out_in;
   assign w5 = w4 ^ rk_data_q[95:64];
   assign w6 = w5 ^ rk_data_q[63:32];
   assign w7 = w6 ^ rk_data_q[31:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (bus.start) next_state = EMIT;
         EMIT:    if (accept && last_key) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // The key register only moves on load or on a handshake, so it is stable while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rk_data_q <= '0;
         rk_idx_q  <= '0;
      end else if ((state == IDLE) && bus.start) begin
         rk_data_q <= bus.key_in;
         rk_idx_q  <= '0;
      end else if (accept && !last_key) begin
         rk_data_q <= {w4, w5, w6, w7};
         rk_idx_q  <= rk_idx_q + 4'd1;
      end
   end

   always_comb begin
      busy_o        = 1'b0;
      rk_valid_o    = 1'b0;
      done_o        = 1'b0;
      g_round_sel_o = 4'd0;
      g_flag_o      = 1'b0;
      unique case (state)
         EMIT: begin
            busy_o     = 1'b1;
            rk_valid_o = 1'b1;
            // Rcon for round idx+1: 01 and 02 come from sel 0 with flag, then sel = round-2.
            unique case (rk_idx_q)
               4'd0: g_round_sel_o = 4'd0;
               4'd1: g_flag_o      = 1'b1;
               4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9:
                  g_round_sel_o = rk_idx_q - 4'd1;
               default: g_round_sel_o = 4'd0;
            endcase
         end
         DONE:    done_o = 1'b1;
         default: ;
      endcase
   end

   assign bus.busy        = busy_o;
   assign bus.rk_valid    = rk_valid_o;
   assign bus.done        = done_o;
   assign bus.rk_idx      = rk_idx_q;
   assign bus.rk_data     = rk_data_q;
   assign bus.g_round_sel = g_round_sel_o;
   assign bus.g_flag      = g_flag_o;
   assign bus.g_w_in      = rk_data_q[31:0];

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Bench for key_sched_ctrl: models the g-function and the full AES-128 key schedule,
// and compares every cycle against a transaction-level model of the round-key stream.
module tb_key_sched_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   key_sched_ctrl_if bus ();

   key_sched_ctrl #(.NUM_ROUNDS(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;

   logic [7:0] sbox_tab [0:255];

   function automatic logic [7:0] xtime(input logic [7:0] c);
      return {c[6:0], 1'b0} ^ (c[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xtime(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rcon_r(input int r);
      logic [7:0] c = 8'h01;
      for (int i = 1; i < r; i++) c = xtime(c);
      return c;
   endfunction

   // S-box built from the GF(2^8) inverse and the affine map, independent of any table.
   initial begin
      logic [7:0] a, inv, s;
      for (int i = 0; i < 256; i++) begin
         a   = 8'(i);
         inv = 8'h00;
         if (a != 8'h00) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, a);
         end
         s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
         sbox_tab[i] = s;
      end
   end

   function automatic logic [127:0] key_at(input logic [127:0] base, input int n);
      logic [31:0] w0, w1, w2, w3, rw, t;
      {w0, w1, w2, w3} = base;
      for (int r = 1; r <= n; r++) begin
         rw = {w3[23:0], w3[31:24]};
         t  = {sbox_tab[rw[31:24]], sbox_tab[rw[23:16]], sbox_tab[rw[15:8]], sbox_tab[rw[7:0]]};
         t  = t ^ {rcon_r(r), 24'h0};
         w0 = w0 ^ t;
         w1 = w1 ^ w0;
         w2 = w2 ^ w1;
         w3 = w3 ^ w2;
      end
      return {w0, w1, w2, w3};
   endfunction

   // External g-function: SubWord(RotWord(w)) ^ Rcon chosen by roundSel/flag.
   logic [7:0]  g_rcon;
   logic [31:0] g_rw;
   logic [31:0] g_val;
   always_comb begin
      if (bus.g_flag)                 g_rcon = 8'h02;
      else if (bus.g_round_sel == 0)  g_rcon = 8'h01;
      else if (bus.g_round_sel <= 8)  g_rcon = rcon_r(int'(bus.g_round_sel) + 2);
      else                            g_rcon = 8'h00;
      g_rw  = {bus.g_w_in[23:0], bus.g_w_in[31:24]};
      g_val = {sbox_tab[g_rw[31:24]], sbox_tab[g_rw[23:16]], sbox_tab[g_rw[15:8]], sbox_tab[g_rw[7:0]]}
              ^ {g_rcon, 24'h0};
   end
   assign bus.g_out_in = g_val;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: which key of which expansion should be on the stream this cycle.
   bit           m_active;
   bit           m_done;
   bit           m_zero;
   int           m_idx;
   logic [127:0] m_base;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 1'b0;
         m_done   <= 1'b0;
         m_zero   <= 1'b1;
         m_idx    <= 0;
         m_base   <= '0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (!m_active) begin
         if (bus.start) begin
            m_active <= 1'b1;
            m_idx    <= 0;
            m_base   <= bus.key_in;
            m_zero   <= 1'b0;
         end
      end else if (bus.rk_ready) begin
         if (m_idx == 10) begin
            m_active <= 1'b0;
            m_done   <= 1'b1;
         end else begin
            m_idx <= m_idx + 1;
         end
      end
   end

   logic [127:0] c_key;
   int           c_round;
   int           c_sel;
   bit           c_flag;
   int           max_sel = 0;

   always @(negedge clk) begin
      if (cmp_en) begin
         if (int'(bus.g_round_sel) > max_sel) max_sel = int'(bus.g_round_sel);
         c_key = m_active ? key_at(m_base, m_idx) : 128'h0;
         checkOutput("rk_valid", 128'(bus.rk_valid), 128'(m_active));
         checkOutput("busy", 128'(bus.busy), 128'(m_active));
         checkOutput("done", 128'(bus.done), 128'(m_done));
         if (m_active || m_zero) begin
            checkOutput("rk_idx", 128'(bus.rk_idx), 128'(m_active ? m_idx : 0));
            checkOutput("rk_data", bus.rk_data, c_key);
            checkOutput("g_w_in", 128'(bus.g_w_in), 128'(c_key[31:0]));
         end
         c_sel  = 0;
         c_flag = 1'b0;
         if (m_active && m_idx < 10) begin
            c_round = m_idx + 1;
            c_flag  = (c_round == 2);
            c_sel   = (c_round <= 2) ? 0 : c_round - 2;
         end
         checkOutput("g_round_sel", 128'(bus.g_round_sel), 128'(c_sel));
         checkOutput("g_flag", 128'(bus.g_flag), 128'(c_flag));
      end
   end

   logic [127:0] cap_key [0:10];
   int           cap_cnt [0:10];

   // One expansion: pulse start, randomise ready (and optionally spam start/key_in), record accepted keys.
   task automatic applyStimulus(input logic [127:0] key, input int ready_pct, input bit spam,
                                output int lat, output int stalls);
      bit r;
      int cyc = 0;
      for (int i = 0; i <= 10; i++) begin
         cap_key[i] = '0;
         cap_cnt[i] = 0;
      end
      lat    = -1;
      stalls = 0;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.key_in   = key;
      bus.rk_ready = ($urandom_range(0, 99) < ready_pct);
      while (cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (bus.done) begin
            lat       = cyc;
            bus.start = 1'b0;
            break;
         end
         if (spam) begin
            bus.start  = 1'($urandom_range(0, 1));
            bus.key_in = {$urandom, $urandom, $urandom, $urandom};
         end else begin
            bus.start = 1'b0;
         end
         r            = ($urandom_range(0, 99) < ready_pct);
         bus.rk_ready = r;
         if (bus.rk_valid && r && bus.rk_idx <= 4'd10) begin
            cap_key[bus.rk_idx] = bus.rk_data;
            cap_cnt[bus.rk_idx]++;
         end
         if (bus.rk_valid && !r) stalls++;
      end
      bus.start = 1'b0;
      checkOutput("done_seen", 128'(lat >= 0), 128'(1));
   endtask

   task automatic checkSeq(input string tag, input logic [127:0] key);
      for (int i = 0; i <= 10; i++) begin
         checkOutput($sformatf("%s_key%0d", tag, i), cap_key[i], key_at(key, i));
         checkOutput($sformatf("%s_cnt%0d", tag, i), 128'(cap_cnt[i]), 128'(1));
      end
   endtask

   initial begin
      int lat, stalls, cyc, pct;
      logic [127:0] rk;
      bus.start    = 1'b0;
      bus.key_in   = '0;
      bus.rk_ready = 1'b0;
      #1 rst_n = 1'b0;
      cmp_en = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("reset_busy", 128'(bus.busy), 128'(0));
      checkOutput("reset_valid", 128'(bus.rk_valid), 128'(0));
      checkOutput("reset_idx", 128'(bus.rk_idx), 128'(0));
      checkOutput("reset_data", bus.rk_data, 128'(0));
      #2 rst_n = 1'b1;

      checkOutput("model_sbox53", 128'(sbox_tab[8'h53]), 128'(8'hed));
      checkOutput("model_k1_idx1", key_at(K1, 1), 128'ha0fafe1788542cb123a339392a6c7605);

      $display("[TB] continuous ready");
      applyStimulus(K1, 100, 1'b0, lat, stalls);
      checkOutput("a_latency", 128'(lat), 128'(12));
      checkOutput("a_idx0", cap_key[0], K1);
      checkOutput("a_idx1", cap_key[1], 128'ha0fafe1788542cb123a339392a6c7605);
      checkOutput("a_idx2", cap_key[2], 128'hf2c295f27a96b9435935807a7359f67f);
      checkOutput("a_idx10", cap_key[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      checkSeq("a", K1);

      $display("[TB] random backpressure");
      applyStimulus(K1, 55, 1'b0, lat, stalls);
      checkOutput("b_latency", 128'(lat), 128'(12 + stalls));
      checkSeq("b", K1);

      $display("[TB] start spam during expansion");
      applyStimulus(K1, 70, 1'b1, lat, stalls);
      checkOutput("d_latency", 128'(lat), 128'(12 + stalls));
      checkSeq("d", K1);

      for (int n = 0; n < 4; n++) begin
         rk  = {$urandom, $urandom, $urandom, $urandom};
         pct = int'($urandom_range(30, 100));
         applyStimulus(rk, pct, 1'($urandom_range(0, 1)), lat, stalls);
         checkOutput("r_latency", 128'(lat), 128'(12 + stalls));
         checkSeq("r", rk);
      end

      $display("[TB] reset at rk_idx 5");
      @(negedge clk);
      bus.start    = 1'b1;
      bus.key_in   = K1;
      bus.rk_ready = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 0;
      while (!(bus.rk_valid && bus.rk_idx == 4'd5) && cyc < 50) begin
         bus.rk_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         cyc++;
      end
      checkOutput("e_reach_idx5", 128'(bus.rk_idx), 128'(5));
      #2 rst_n = 1'b0;
      #1;
      checkOutput("e_busy", 128'(bus.busy), 128'(0));
      checkOutput("e_valid", 128'(bus.rk_valid), 128'(0));
      checkOutput("e_done", 128'(bus.done), 128'(0));
      checkOutput("e_idx", 128'(bus.rk_idx), 128'(0));
      checkOutput("e_data", bus.rk_data, 128'(0));
      checkOutput("e_sel", 128'(bus.g_round_sel), 128'(0));
      checkOutput("e_flag", 128'(bus.g_flag), 128'(0));
      @(negedge clk);
      #2 rst_n = 1'b1;
      applyStimulus(K2, 100, 1'b0, lat, stalls);
      checkOutput("e_latency", 128'(lat), 128'(12));
      checkOutput("e_idx10", cap_key[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
      checkSeq("e", K2);

      $display("[TB] start held high");
      @(negedge clk);
      bus.start    = 1'b1;
      bus.key_in   = K2;
      bus.rk_ready = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!bus.done && cyc < 50);
      checkOutput("f_done1", 128'(bus.done), 128'(1));
      @(negedge clk);
      checkOutput("f_gap_valid", 128'(bus.rk_valid), 128'(0));
      checkOutput("f_gap_busy", 128'(bus.busy), 128'(0));
      @(negedge clk);
      checkOutput("f_next_valid", 128'(bus.rk_valid), 128'(1));
      checkOutput("f_next_idx", 128'(bus.rk_idx), 128'(0));
      checkOutput("f_next_data", bus.rk_data, K2);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!bus.done && cyc < 50);
      bus.start = 1'b0;
      checkOutput("f_done2", 128'(bus.done), 128'(1));
      checkOutput("f_done2_cycles", 128'(cyc), 128'(11));
      repeat (3) @(negedge clk);

      checkOutput("max_sel", 128'(max_sel), 128'(8));
      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/key_sched_ctrl.md
Name: key_sched_ctrl

Overview:
Sequencer for AES-128 key expansion around the shared g-function datapath (S-box on rotated word plus Rcon XOR). On a start request it latches the cipher key, then produces round keys 0..10 one at a time through a valid/ready stream. Round key N+1 is computed from key N in the cycle key N is accepted. It sits between the key input register and the round-key consumer, either the cipher core or a key RAM writer.

Parameters:
NUM_ROUNDS, 10, number of expansion rounds; only 10 is legal (AES-128). Other values are a synthesis-time error.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request new expansion; sampled only in IDLE
key_in  input  128  cipher key; word w0 = key_in[127:96]
busy  output  1  high from the cycle after accepted start until done
rk_valid  output  1  rk_data/rk_idx hold a valid round key
rk_ready  input  1  consumer accepts round key when high with rk_valid
rk_idx  output  4  round key index 0..10
rk_data  output  128  current round key, w[4i] in [127:96]
done  output  1  one-cycle pulse after round key 10 is accepted
g_round_sel  output  4  to g roundSel
g_flag  output  1  to g flag
g_w_in  output  32  to g w_in, always rk_data[31:0]
g_out_in  input  32  from g g_out, combinational

Behaviour:
- Reset (async, rst_n=0) has these values:
  - state=IDLE
  - busy=0, rk_valid=0, done=0
  - rk_idx=0, rk_data=0
  - g_round_sel=0, g_flag=0
  - Reset mid-expansion aborts immediately. The consumer must discard partial keys.
- FSM states:
  - IDLE:
    - start=1 loads rk_data<=key_in and rk_idx<=0.
    - Next state is EMIT. busy=1 and rk_valid=1 appear the following cycle.
    - start=0 stays in IDLE.
  - EMIT: rk_valid=1.
    - If rk_ready=0: hold rk_data, rk_idx and g controls stable. No change is allowed while valid and not accepted.
    - If rk_ready=1 and rk_idx<10: latch the next key and increment rk_idx.
      - rk_valid stays 1, giving one key per cycle under continuous ready.
      - Next key: w4=w0^g_out_in, w5=w4^w1, w6=w5^w2, w7=w6^w3, where w0..w3 are the current rk_data words from MSB.
    - If rk_ready=1 and rk_idx=10: go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, rk_valid=0, then IDLE.
    - start is not sampled in DONE. The earliest restart is the first IDLE cycle.
- g control: combinational decode of rk_idx, valid while in EMIT. Target round r = rk_idx+1.
  - r=1: sel=0, flag=0 (Rcon 01).
  - r=2: sel=0, flag=1 (Rcon 02).
  - r=3..10: sel=r-2, flag=0 (Rcon 04,08,10,20,40,80,1B,36).
  - rk_idx=10 and IDLE/DONE: sel=0, flag=0. The g output is unused.
  - sel is never driven to 9..15. g holds Rcon on undefined values, so those are forbidden.
- start while busy is ignored, and key_in changes during expansion have no effect.
- rk_ready may be high while rk_valid=0 with no effect.
- Latency:
  - start to first rk_valid is 1 cycle.
  - With continuous rk_ready, start to done is 12 cycles.
  - Every cycle of rk_ready=0 adds one cycle.

Test Plan:
- Reset then start with key_in=2b7e151628aed2a6abf7158809cf4f3c and rk_ready=1 constantly:
  - idx0 = key_in
  - idx1 = a0fafe1788542cb123a339392a6c7605
  - idx2 = f2c295f27a96b9435935807a7359f67f
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - done pulses 12 cycles after start.
- Same key with rk_ready toggled pseudo-randomly -> identical 11-key sequence. rk_data/rk_idx are stable on every valid&!ready cycle. Each index is emitted exactly once.
- Monitor g_round_sel/g_flag per rk_idx 0..9 -> (0,0),(0,1),(1,0)..(8,0). sel is never >8 during the run.
- Assert start repeatedly mid-expansion with a different key_in -> sequence unaffected, no extra done.
- Drop rst_n low at rk_idx=5 -> all outputs zero asynchronously. A new start with key 000102030405060708090a0b0c0d0e0f gives idx10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Hold start=1 continuously -> back-to-back expansions. done, then 1 IDLE cycle, then the next rk_valid idx0.
